outport_vc_arbiter: RTL and testbench

//  Per-output-port switch and VC allocator for the hypercube router. Sits between the

---
 rtl/outport_vc_arbiter_pkg.sv | 11 +
 rtl/outport_vc_arbiter_rr_arbiter.sv | 32 +++
 rtl/outport_vc_arbiter.sv | 120 ++++++++++++
 tb/tb_outport_vc_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/outport_vc_arbiter_pkg.sv
// Shared definitions for the per-output-port switch/VC allocator:
// FSM state encoding and the state type used by the top level.
package outport_vc_arbiter_pkg;

    typedef logic [0:0] arb_state_t;

    // Legacy-compatible state encoding
    localparam arb_state_t ST_IDLE = 1'b0;
    localparam arb_state_t ST_XFER = 1'b1;

endpackage

// File: rtl/outport_vc_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. The requester at index 'ptr' has the
// highest priority, then ptr+1, ... wrapping around N-1 -> 0.
// Produces a one-hot grant, its binary index and an "any request" flag.
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from lowest to highest priority so the highest-priority hit is the last one written
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt                        = '0;
                gnt[(int'(ptr) + k) % N]   = 1'b1;
                idx                        = W'((int'(ptr) + k) % N);
                any                        = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/outport_vc_arbiter.sv
// Per-output-port switch and VC allocator. In IDLE it picks one head-flit
// requester round-robin and binds it to the lowest free downstream VC; in
// XFER it forwards that owner's flits (wormhole) until its tail has moved.
// Every packet boundary passes through IDLE for one cycle.
module outport_vc_arbiter
    import outport_vc_arbiter_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PORTID   = 0,
    parameter int NUM_IN   = 5,
    parameter int NUM_VC   = 4,
    parameter int VC_W     = 2,
    parameter int SEL_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] req,
    input  logic [NUM_IN-1:0] req_head,
    input  logic [NUM_IN-1:0] req_tail,
    input  logic [NUM_VC-1:0] vc_lck,
    input  logic [NUM_VC-1:0] vc_rdy,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  xbar_sel,
    output logic [VC_W-1:0]   out_vch,
    output logic              fwd,
    output logic              busy
);

    arb_state_t        state_r;
    logic [SEL_W-1:0]  rr_ptr_r;
    logic [SEL_W-1:0]  rr_next_s;
    logic [NUM_IN-1:0] eligible_s;
    logic [NUM_IN-1:0] arb_gnt_s;
    logic [SEL_W-1:0]  arb_idx_s;
    logic              arb_any_s;
    logic [NUM_VC-1:0] free_vc_s;
    logic [VC_W-1:0]   vc_idx_s;
    logic              vc_any_s;
    logic              tail_xfer_s;

    // Only head flits may open a packet; body/tail requests in IDLE are ignored
    assign eligible_s  = req & req_head;
    assign free_vc_s   = ~vc_lck & vc_rdy;
    assign busy        = (state_r == ST_XFER);
    assign fwd         = busy & req[xbar_sel];
    assign tail_xfer_s = fwd & req_tail[xbar_sel];

    rr_arbiter #(
        .N (NUM_IN),
        .W (SEL_W)
    ) u_rr (
        .req (eligible_s),
        .ptr (rr_ptr_r),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s),
        .any (arb_any_s)
    );

    // Lowest-index free VC wins; scan downwards so the lowest hit is written last
    always_comb begin
        vc_idx_s = '0;
        vc_any_s = 1'b0;
        for (int j = NUM_VC - 1; j >= 0; j--) begin
            if (free_vc_s[j]) begin
                vc_idx_s = VC_W'(j);
                vc_any_s = 1'b1;
            end else begin
                vc_any_s = vc_any_s;
            end
        end
    end

    // Round-robin pointer moves to the input just after the finishing owner
    always_comb begin
        if (xbar_sel == SEL_W'(NUM_IN - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = xbar_sel + SEL_W'(1);
        end
    end

    // Allocation FSM and registered grant/select/VC outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            grant    <= '0;
            xbar_sel <= '0;
            out_vch  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arb_any_s && vc_any_s) begin
                        grant    <= arb_gnt_s;
                        xbar_sel <= arb_idx_s;
                        out_vch  <= vc_idx_s;
                        state_r  <= ST_XFER;
                    end else begin
                        grant    <= '0;
                    end
                end
                ST_XFER: begin
                    // A stalled owner (req low) simply holds every register
                    if (tail_xfer_s) begin
                        grant    <= '0;
                        rr_ptr_r <= rr_next_s;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= ST_XFER;
                    end
                end
                default: begin
                    grant   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outport_vc_arbiter.sv
// Self-checking bench for outport_vc_arbiter. A packet-level reference model
// (owner index, round-robin pointer, bound VC, per-input flit counters)
// predicts every output each cycle; stimulus is directed scenarios followed
// by randomized traffic.
module tb_outport_vc_arbiter;

    localparam int NUM_IN = 5;
    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;
    localparam int SEL_W  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NUM_IN-1:0] req = '0;
    logic [NUM_IN-1:0] req_head = '0;
    logic [NUM_IN-1:0] req_tail = '0;
    logic [NUM_VC-1:0] vc_lck = '0;
    logic [NUM_VC-1:0] vc_rdy = '0;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  xbar_sel;
    logic [VC_W-1:0]   out_vch;
    logic              fwd;
    logic              busy;

    int checks = 0;
    int failures = 0;

    // Reference model: -1 means no owner (IDLE)
    int m_owner = -1;
    int m_rr    = 0;
    int m_vch   = 0;
    // Traffic: packet length per input (0 = none pending) and flits already sent
    int pk_len  [NUM_IN];
    int pk_sent [NUM_IN];
    logic [NUM_IN-1:0] drop = '0;

    outport_vc_arbiter #(
        .ROUTERID (0),
        .PORTID   (0),
        .NUM_IN   (NUM_IN),
        .NUM_VC   (NUM_VC),
        .VC_W     (VC_W),
        .SEL_W    (SEL_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_head (req_head),
        .req_tail (req_tail),
        .vc_lck   (vc_lck),
        .vc_rdy   (vc_rdy),
        .grant    (grant),
        .xbar_sel (xbar_sel),
        .out_vch  (out_vch),
        .fwd      (fwd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_traffic();
        for (int i = 0; i < NUM_IN; i++) begin
            pk_len[i]  = 0;
            pk_sent[i] = 0;
        end
        drop = '0;
    endtask

    // Present the head-of-line flit of every pending packet unless stalled
    task automatic build_inputs();
        for (int i = 0; i < NUM_IN; i++) begin
            if (pk_len[i] > 0 && !drop[i]) begin
                req[i]      = 1'b1;
                req_head[i] = (pk_sent[i] == 0);
                req_tail[i] = (pk_sent[i] == pk_len[i] - 1);
            end else begin
                req[i]      = 1'b0;
                req_head[i] = 1'b0;
                req_tail[i] = 1'b0;
            end
        end
    endtask

    // Advance the packet-level model across one rising edge
    task automatic model_edge();
        int  o;
        int  pick;
        int  vc;
        logic last;
        if (m_owner >= 0) begin
            o = m_owner;
            if (req[o]) begin
                last = req_tail[o];
                pk_sent[o]++;
                if (pk_sent[o] >= pk_len[o]) begin
                    pk_len[o]  = 0;
                    pk_sent[o] = 0;
                end
                if (last) begin
                    m_rr    = (o + 1) % NUM_IN;
                    m_owner = -1;
                end
            end
        end else begin
            pick = -1;
            for (int k = 0; k < NUM_IN; k++) begin
                if (pick < 0 && req[(m_rr + k) % NUM_IN] && req_head[(m_rr + k) % NUM_IN])
                    pick = (m_rr + k) % NUM_IN;
            end
            vc = -1;
            for (int j = 0; j < NUM_VC; j++) begin
                if (vc < 0 && !vc_lck[j] && vc_rdy[j])
                    vc = j;
            end
            if (pick >= 0 && vc >= 0) begin
                m_owner = pick;
                m_vch   = vc;
            end
        end
    endtask

    // One clock cycle: drive, compare just after drive, then clock the model
    task automatic cycle(input string tag);
        logic [NUM_IN-1:0] eg;
        build_inputs();
        #1;
        eg = (m_owner < 0) ? '0 : (NUM_IN'(1) << m_owner);
        check($sformatf("%s.grant", tag), 32'(grant), 32'(eg));
        check($sformatf("%s.busy", tag), 32'(busy), 32'(m_owner >= 0));
        check($sformatf("%s.fwd", tag), 32'(fwd), 32'(m_owner >= 0 && req[m_owner]));
        if (m_owner >= 0) begin
            check($sformatf("%s.xbar_sel", tag), 32'(xbar_sel), 32'(m_owner));
            check($sformatf("%s.out_vch", tag), 32'(out_vch), 32'(m_vch));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s.grant", tag), 32'(grant), 32'd0);
        check($sformatf("%s.xbar_sel", tag), 32'(xbar_sel), 32'd0);
        check($sformatf("%s.out_vch", tag), 32'(out_vch), 32'd0);
        check($sformatf("%s.fwd", tag), 32'(fwd), 32'd0);
        check($sformatf("%s.busy", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        clear_traffic();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: single 3-flit packet on input 0, only VC0 free
        vc_lck = 4'b0000; vc_rdy = 4'b0001;
        pk_len[0] = 3;
        repeat (5) cycle("t1");

        // 2: inputs 1, 2, 4 compete; served 1, 2, 4 with IDLE gaps
        vc_rdy = 4'b1111;
        pk_len[1] = 2; pk_len[2] = 2; pk_len[4] = 2;
        repeat (11) cycle("t2");

        // 3: VC0/1 locked -> VC2; then no ready VC until vc_rdy[3] rises
        vc_lck = 4'b0011; vc_rdy = 4'b1111;
        pk_len[0] = 1;
        repeat (3) cycle("t3a");
        vc_lck = 4'b0000; vc_rdy = 4'b0000;
        pk_len[3] = 2;
        repeat (3) cycle("t3b");
        vc_rdy = 4'b1000;
        repeat (4) cycle("t3c");

        // 4: owner stalls two cycles while input 3 waits
        vc_rdy = 4'b1111;
        pk_len[0] = 4;
        repeat (2) cycle("t4a");
        drop = 5'b00001;
        pk_len[3] = 1;
        repeat (2) cycle("t4b");
        drop = 5'b00000;
        repeat (8) cycle("t4c");

        // 5: head+tail on input 2 -> one fwd cycle, pointer moves to 3
        pk_len[2] = 1;
        repeat (3) cycle("t5a");
        pk_len[0] = 1; pk_len[3] = 1;
        repeat (5) cycle("t5b");

        // 6: asynchronous reset in the middle of a 4-flit packet
        pk_len[1] = 4;
        repeat (3) cycle("t6a");
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6_async");
        clear_traffic();
        build_inputs();
        m_owner = -1; m_rr = 0; m_vch = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pk_len[4] = 2;
        repeat (5) cycle("t6b");

        // Randomized traffic with stalls and changing VC status
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (pk_len[i] == 0 && ($urandom % 6) == 0)
                    pk_len[i] = int'($urandom_range(1, 4));
            end
            drop   = NUM_IN'($urandom & $urandom & $urandom);
            vc_lck = NUM_VC'($urandom);
            vc_rdy = NUM_VC'($urandom);
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
